// File: rtl/cm_arb_xfer.sv
// Packet transfer front-end for an external weighted arbiter.
// It launches one request per idle cycle and waits for a grant index, with a timeout.
// The granted source's packet is then forwarded combinationally until its last beat.
module cm_arb_xfer #(
    parameter int DCNT   = 4,
    parameter int DWIDTH = 32,
    parameter int WWIDTH = 8,
    parameter int TMO    = 15,
    localparam int IDX_WIDTH = (DCNT > 1) ? $clog2(DCNT) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [DCNT-1:0]          i_vld,
    input  logic [DCNT*DWIDTH-1:0]   i_data,
    input  logic [DCNT-1:0]          i_last,
    input  logic [DCNT*WWIDTH-1:0]   i_weight,
    output logic [DCNT-1:0]          o_rdy,
    output logic [DCNT-1:0]          o_arb_req,
    output logic [DCNT*WWIDTH-1:0]   o_arb_weight,
    input  logic                     i_arb_vld,
    input  logic [IDX_WIDTH-1:0]     i_arb_gnt,
    output logic                     o_vld,
    output logic [DWIDTH-1:0]        o_data,
    output logic                     o_last,
    input  logic                     i_rdy,
    output logic                     o_busy,
    output logic                     o_err
);

    localparam int CNT_W      = ($clog2(TMO + 1) > 4) ? $clog2(TMO + 1) : 4;
    // The timeout fires in this WAIT count so that the registered pulse
    // appears exactly TMO cycles after the launch cycle.
    localparam int TMO_LAST_I = (TMO > 1) ? TMO - 2 : 0;
    localparam logic [CNT_W-1:0]     TMO_LAST = CNT_W'(TMO_LAST_I);
    localparam logic [IDX_WIDTH:0]   DCNT_W   = (IDX_WIDTH + 1)'(DCNT);

    typedef enum logic [1:0] {StIdle, StWait, StXfer} state_t;

    state_t               state_q;
    logic [IDX_WIDTH-1:0] grant_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 err_q;
    logic                 gnt_ok;
    logic                 xfer_done;

    // Extra MSB keeps the range check meaningful when DCNT is a power of two.
    assign gnt_ok    = ({1'b0, i_arb_gnt} < DCNT_W);
    assign xfer_done = o_vld & i_rdy & o_last;

    // Control FSM: launch, wait for grant or timeout, hold grant for one packet.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= StIdle;
            grant_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (|i_vld) begin
                        cnt_q   <= '0;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (i_arb_vld) begin
                        if (gnt_ok) begin
                            grant_q <= i_arb_gnt;
                            state_q <= StXfer;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= StIdle;
                        end
                    end else if (cnt_q >= TMO_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                StXfer: begin
                    if (xfer_done) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Request launch and zero-latency downstream mux from the granted source.
    always_comb begin
        o_arb_req    = '0;
        o_arb_weight = '0;
        o_vld        = 1'b0;
        o_data       = '0;
        o_last       = 1'b0;
        o_rdy        = '0;
        // Reset gating keeps the combinational launch quiet while reset is held.
        if (i_rst && (state_q == StIdle) && (|i_vld)) begin
            o_arb_req    = i_vld;
            o_arb_weight = i_weight;
        end
        if (state_q == StXfer) begin
            for (int i = 0; i < DCNT; i++) begin
                if (grant_q == IDX_WIDTH'(i)) begin
                    o_vld    = i_vld[i];
                    o_data   = i_data[i*DWIDTH +: DWIDTH];
                    o_last   = i_last[i];
                    o_rdy[i] = i_rdy;
                end
            end
        end
    end

    assign o_busy = (state_q != StIdle);
    assign o_err  = err_q;

endmodule

// File: doc/cm_arb_xfer.md
CM_ARB_XFER -- requirements
Module: cm_arb_xfer

Interface
REQ-001 SHALL have parameter DCNT, default 4, number of requesting sources.
REQ-002 SHALL have parameter DWIDTH, default 32, payload width per beat.
REQ-003 SHALL have parameter WWIDTH, default 8, arbitration weight width.
REQ-004 SHALL have parameter TMO, default 15, maximum cycles from request launch to grant.
REQ-005 SHALL have localparam IDX_WIDTH = sclog2(DCNT).
REQ-006 SHALL have port i_clk, input, 1, sole clock; all logic on its rising edge.
REQ-007 SHALL have port i_rst, input, 1; reset is asynchronous and active-low.
REQ-008 SHALL have port i_vld, input, DCNT, per-source beat valid.
REQ-009 SHALL have port i_data, input, DCNT x DWIDTH, per-source payload.
REQ-010 SHALL have port i_last, input, DCNT, per-source end-of-packet marker.
REQ-011 SHALL have port i_weight, input, DCNT x WWIDTH, per-source priority weight.
REQ-012 SHALL have port o_rdy, output, DCNT, per-source beat accept.
REQ-013 SHALL have port o_arb_req, output, DCNT, request vector to arbiter.
REQ-014 SHALL have port o_arb_weight, output, DCNT x WWIDTH, weight vector to arbiter.
REQ-015 SHALL have port i_arb_vld, input, 1, arbiter result valid.
REQ-016 SHALL have port i_arb_gnt, input, IDX_WIDTH, arbiter winning index.
REQ-017 SHALL have port o_vld / o_data / o_last, output, 1 / DWIDTH / 1, downstream beat.
REQ-018 SHALL have port i_rdy, input, 1, downstream accept.
REQ-019 SHALL have port o_busy, output, 1, high in any state except IDLE.
REQ-020 SHALL have port o_err, output, 1, single-cycle error pulse.

Function
REQ-021 SHALL implement a registered FSM with states IDLE, WAIT, XFER.
REQ-022 IDLE: if |i_vld, drive o_arb_req = i_vld and o_arb_weight = i_weight for exactly that cycle, clear timeout counter, go WAIT; else o_arb_req = 0, stay IDLE.
REQ-023 WAIT: o_arb_req = 0; increment 4-bit-min timeout counter each cycle.
REQ-024 WAIT: on i_arb_vld with i_arb_gnt < DCNT, register gnt into grant register, go XFER.
REQ-025 WAIT: on i_arb_vld with i_arb_gnt >= DCNT, pulse o_err, go IDLE.
REQ-026 WAIT: if counter reaches TMO without i_arb_vld, pulse o_err, go IDLE.
REQ-027 i_arb_vld outside WAIT SHALL be ignored.
REQ-028 XFER: o_vld = i_vld[g], o_data = i_data[g], o_last = i_last[g], o_rdy[g] = i_rdy, o_rdy[others] = 0, g = grant register.
REQ-029 XFER: a beat transfers when o_vld & i_rdy; grant SHALL be held across stalls (i_vld[g] low or i_rdy low) indefinitely.
REQ-030 XFER: transfer of a beat with o_last = 1 SHALL return FSM to IDLE next cycle; new arbitration may launch that IDLE cycle.
REQ-031 Outside XFER: o_vld, o_last, o_rdy = 0; o_data = 0.
REQ-032 Downstream path SHALL be combinational from sources (zero added latency); launch-to-grant latency equals arbiter latency.
REQ-033 Packets SHALL never interleave; a grant covers exactly one packet.
REQ-034 o_err SHALL be registered, high for one cycle per error event.

Reset
REQ-035 i_rst low SHALL asynchronously force state IDLE, grant register 0, timeout counter 0, o_err 0; all outputs 0 while asserted.
REQ-036 Reset mid-XFER SHALL abandon the packet without a further o_rdy; after release, arbitration restarts from IDLE.

Verification
REQ-037 DCNT=4, i_vld=4'b0101, arbiter returns gnt=2 after 2 cycles -> o_arb_req=4'b0101 one cycle, o_busy high, source 2 beats forwarded, o_rdy=4'b0100 while i_rdy high.
REQ-038 Granted source sends 3 beats, i_rdy low on beat 2 for 4 cycles -> o_data held stable, 3 transfers, IDLE one cycle after last beat.
REQ-039 No i_arb_vld for TMO=15 cycles after launch -> o_err pulse at cycle 15, state IDLE, o_busy low.
REQ-040 DCNT=3, i_arb_gnt=3 with i_arb_vld -> o_err pulse, no o_rdy asserted, IDLE.
REQ-041 i_rst low during beat 2 of 4-beat packet -> all outputs 0 immediately; after release with i_vld=4'b1000, new launch with o_arb_req=4'b1000.
REQ-042 Two back-to-back packets from different sources -> no interleaving, second launch exactly one cycle after first o_last transfer.
